dcache_ctrl: RTL and testbench

//  MEM-stage responder to the EX/MEM pipeline register: services MemRead/MemWrite

---
 rtl/dcache_pkg.sv | 22 ++
 rtl/dcache_array.sv | 64 ++++++
 rtl/dcache_ctrl.sv | 151 +++++++++++++++
 tb/tb_dcache_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the L1 data cache controller.
// Holds default geometry, derived field widths and the miss-handling FSM
// state encoding.
package dcache_pkg;

  localparam int LINES      = 32;
  localparam int BLOCK_BITS = 256;
  localparam int ADDR_W     = 32;

  localparam int IDX_W = $clog2(LINES);
  localparam int OFF_W = $clog2(BLOCK_BITS / 8);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int WORDS = BLOCK_BITS / 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WBACK = 2'd1,
    FETCH = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/dcache_array.sv
// Tag / valid / dirty / data storage for a direct-mapped cache.
// Ports:
//   clk, rst_n      clock, async active-low reset (clears valid and dirty only)
//   idx             line index shared by the read and write ports
//   rd_valid/dirty  status bits of the indexed line (combinational)
//   rd_tag/rd_data  stored tag and block of the indexed line (combinational)
//   wr_en           write the indexed line at the clock edge
//   wr_fill         1: refill (load tag, valid=1, dirty=0); 0: store (dirty=1)
//   wr_tag          tag written on a refill
//   wr_mask         per-32-bit-word write enables
//   wr_data         block-wide write data, merged under wr_mask
module dcache_array #(
  parameter  int LINES      = dcache_pkg::LINES,
  parameter  int BLOCK_BITS = dcache_pkg::BLOCK_BITS,
  parameter  int TAG_W      = dcache_pkg::TAG_W,
  localparam int IDX_W      = $clog2(LINES),
  localparam int WORDS      = BLOCK_BITS / 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IDX_W-1:0]      idx,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [BLOCK_BITS-1:0] rd_data,
  input  logic                  wr_en,
  input  logic                  wr_fill,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [WORDS-1:0]      wr_mask,
  input  logic [BLOCK_BITS-1:0] wr_data
);

  logic [TAG_W-1:0]      tag_mem  [LINES];
  logic [BLOCK_BITS-1:0] data_mem [LINES];
  logic [LINES-1:0]      valid_q;
  logic [LINES-1:0]      dirty_q;

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_mem[idx];
  assign rd_data  = data_mem[idx];

  // NOTE: tag and data arrays have no reset so they map onto plain RAM;
  // the valid bits alone make their power-up contents harmless.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_fill) tag_mem[idx] <= wr_tag;
      for (int w = 0; w < WORDS; w++) begin
        if (wr_mask[w]) data_mem[idx][w*32 +: 32] <= wr_data[w*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[idx] <= valid_q[idx] | wr_fill;
      dirty_q[idx] <= !wr_fill;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// MEM-stage L1 data cache: direct-mapped, write-back, write-allocate.
// Ports:
//   Clock_i, Reset_n_i        clock, async active-low reset
//   MemRead_i, MemWrite_i     load / store request (both set = store)
//   Addr_i, WriteData_i       byte address and store data (word access only)
//   ReadData_o                load data, valid when MemRead_i=1 and stall_o=0
//   stall_o                   freezes the pipeline while a miss is serviced
//   mem_enable_o/mem_write_o  block request valid / 1=write-back, 0=fetch
//   mem_addr_o, mem_data_o    block-aligned address, eviction data
//   mem_data_i, mem_ack_i     fetch data, one-cycle completion pulse
module dcache_ctrl #(
  parameter int LINES      = dcache_pkg::LINES,
  parameter int BLOCK_BITS = dcache_pkg::BLOCK_BITS,
  parameter int ADDR_W     = dcache_pkg::ADDR_W
) (
  input  logic                  Clock_i,
  input  logic                  Reset_n_i,
  input  logic                  MemRead_i,
  input  logic                  MemWrite_i,
  input  logic [ADDR_W-1:0]     Addr_i,
  input  logic [31:0]           WriteData_i,
  output logic [31:0]           ReadData_o,
  output logic                  stall_o,
  output logic                  mem_enable_o,
  output logic                  mem_write_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [BLOCK_BITS-1:0] mem_data_o,
  input  logic [BLOCK_BITS-1:0] mem_data_i,
  input  logic                  mem_ack_i
);
  import dcache_pkg::*;

  localparam int IDX_W  = $clog2(LINES);
  localparam int OFF_W  = $clog2(BLOCK_BITS / 8);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WORDS  = BLOCK_BITS / 32;
  localparam int WSEL_W = OFF_W - 2;

  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  idx;
  logic [WSEL_W-1:0] word_sel;
  logic              unused_byte_bits;

  assign tag              = Addr_i[ADDR_W-1 -: TAG_W];
  assign idx              = Addr_i[OFF_W +: IDX_W];
  assign word_sel         = Addr_i[2 +: WSEL_W];
  assign unused_byte_bits = ^Addr_i[1:0];

  logic                       line_valid, line_dirty;
  logic [TAG_W-1:0]           line_tag;
  logic [BLOCK_BITS-1:0]      line_data;
  logic [WORDS-1:0][31:0]     line_words;
  logic                       wr_en, wr_fill;
  logic [WORDS-1:0]           wr_mask;
  logic [BLOCK_BITS-1:0]      wr_data;

  state_t state;
  logic   req, hit, fill, store;

  assign line_words = line_data;
  assign req        = MemRead_i | MemWrite_i;
  assign hit        = line_valid && (line_tag == tag);

  // Refill lands on the FETCH ack edge; the pending store (if any) then
  // merges in DONE, where the access has become an ordinary hit.
  assign fill    = (state == FETCH) && mem_ack_i;
  assign store   = MemWrite_i && hit && ((state == IDLE) || (state == DONE));
  assign wr_en   = fill || store;
  assign wr_fill = fill;
  assign wr_mask = fill ? '1 : (WORDS'(1) << word_sel);
  assign wr_data = fill ? mem_data_i : {WORDS{WriteData_i}};

  dcache_array #(
    .LINES      (LINES),
    .BLOCK_BITS (BLOCK_BITS),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk      (Clock_i),
    .rst_n    (Reset_n_i),
    .idx      (idx),
    .rd_valid (line_valid),
    .rd_dirty (line_dirty),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (wr_en),
    .wr_fill  (wr_fill),
    .wr_tag   (tag),
    .wr_mask  (wr_mask),
    .wr_data  (wr_data)
  );

  // NOTE: every output of an always_comb gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    stall_o = 1'b0;
    unique case (state)
      IDLE:         stall_o = req && !hit;
      WBACK, FETCH: stall_o = 1'b1;
      default:      stall_o = 1'b0;
    endcase
  end

  assign ReadData_o = (MemRead_i && !stall_o) ? line_words[word_sel] : 32'd0;

  // NOTE: state and memory-port registers use non-blocking assignments so
  // every flop samples pre-edge values, independent of statement order.
  always_ff @(posedge Clock_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      state        <= IDLE;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req && !hit) begin
            mem_enable_o <= 1'b1;
            if (line_valid && line_dirty) begin
              state       <= WBACK;
              mem_write_o <= 1'b1;
              mem_addr_o  <= {line_tag, idx, {OFF_W{1'b0}}};
              mem_data_o  <= line_data;
            end else begin
              state       <= FETCH;
              mem_write_o <= 1'b0;
              mem_addr_o  <= {tag, idx, {OFF_W{1'b0}}};
            end
          end
        end
        WBACK: begin
          if (mem_ack_i) begin
            state       <= FETCH;
            mem_write_o <= 1'b0;
            mem_addr_o  <= {tag, idx, {OFF_W{1'b0}}};
            mem_data_o  <= '0;
          end
        end
        FETCH: begin
          if (mem_ack_i) begin
            state        <= DONE;
            mem_enable_o <= 1'b0;
            mem_addr_o   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl: refill, hit/store, dirty
// eviction, combined read+write, reset during fetch, stray ack while idle.
module tb_dcache_ctrl;

  logic         Clock_i = 1'b0;
  logic         Reset_n_i;
  logic         MemRead_i, MemWrite_i;
  logic [31:0]  Addr_i, WriteData_i, ReadData_o;
  logic         stall_o, mem_enable_o, mem_write_o, mem_ack_i;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i;

  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;
  int base;
  logic [255:0] seen, exp_blk;

  dcache_ctrl dut (
    .Clock_i      (Clock_i),
    .Reset_n_i    (Reset_n_i),
    .MemRead_i    (MemRead_i),
    .MemWrite_i   (MemWrite_i),
    .Addr_i       (Addr_i),
    .WriteData_i  (WriteData_i),
    .ReadData_o   (ReadData_o),
    .stall_o      (stall_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i)
  );

  always #5 Clock_i = ~Clock_i;

  always @(negedge Clock_i) if (stall_o) stall_cnt++;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge Clock_i);
    #1;
  endtask

  function automatic logic [255:0] blk(input logic [31:0] b);
    logic [255:0] r;
    for (int w = 0; w < 8; w++) r[w*32 +: 32] = b + 32'(w);
    return r;
  endfunction

  // Waits for a memory request, checks it, acks on the lat-th request cycle.
  // Returns in the cycle following the ack.
  task automatic serve(input string tag, input int lat, input logic exp_w,
                       input logic [31:0] exp_a, input logic [255:0] fill,
                       output logic [255:0] wdata);
    int k;
    for (k = 0; k < 50; k++) begin
      if (mem_enable_o) break;
      step();
    end
    if (k == 50) begin
      check({tag, "_req_timeout"}, 1'b0, 1'b1);
      wdata = '0;
      return;
    end
    check({tag, "_write"}, mem_write_o, exp_w);
    check({tag, "_addr"}, mem_addr_o, exp_a);
    wdata = mem_data_o;
    repeat (lat - 1) step();
    mem_ack_i  = 1'b1;
    mem_data_i = fill;
    step();
    mem_ack_i  = 1'b0;
  endtask

  initial begin
    Reset_n_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
    Addr_i = '0; WriteData_i = '0; mem_ack_i = 1'b0; mem_data_i = '0;
    repeat (2) step();
    check("rst_stall", stall_o, 1'b0);
    check("rst_rdata", ReadData_o, 32'd0);
    check("rst_enable", mem_enable_o, 1'b0);
    check("rst_maddr", mem_addr_o, 32'd0);
    Reset_n_i = 1'b1;
    step();

    // 1: cold miss on 0x40, 10-cycle fetch
    exp_blk = blk(32'hA0A0_0000);
    exp_blk[31:0]  = 32'h1111_0000;
    exp_blk[63:32] = 32'hDEAD_BEEF;
    MemRead_i = 1'b1; Addr_i = 32'h40; base = stall_cnt;
    #1 check("t1_miss_stall", stall_o, 1'b1);
    serve("t1_fetch", 10, 1'b0, 32'h40, exp_blk, seen);
    check("t1_done_stall", stall_o, 1'b0);
    check("t1_done_rdata", ReadData_o, 32'h1111_0000);
    check("t1_enable_drop", mem_enable_o, 1'b0);
    check("t1_stall_cycles", 32'(stall_cnt - base), 32'd11);
    step();
    Addr_i = 32'h44;
    #1 check("t1_hit_rdata", ReadData_o, 32'hDEAD_BEEF);
    check("t1_hit_stall", stall_o, 1'b0);
    step();
    check("t1_no_req", mem_enable_o, 1'b0);

    // 2: store hit on 0x48, then read back
    MemRead_i = 1'b0; MemWrite_i = 1'b1; Addr_i = 32'h48; WriteData_i = 32'h1234_5678;
    #1 check("t2_store_stall", stall_o, 1'b0);
    step();
    MemWrite_i = 1'b0; MemRead_i = 1'b1;
    #1 check("t2_load_rdata", ReadData_o, 32'h1234_5678);
    step();

    // 3: conflict miss on 0x448 evicts dirty line 0x40
    Addr_i = 32'h448; base = stall_cnt;
    exp_blk[95:64] = 32'h1234_5678;
    #1 check("t3_miss_stall", stall_o, 1'b1);
    serve("t3_wb", 3, 1'b1, 32'h40, '0, seen);
    check("t3_wb_data", seen, exp_blk);
    serve("t3_fetch", 5, 1'b0, 32'h440, blk(32'hB0B0_0000), seen);
    check("t3_done_rdata", ReadData_o, 32'hB0B0_0002);
    check("t3_stall_cycles", 32'(stall_cnt - base), 32'd9);
    step();

    // 4: read+write on a clean miss -> store after refill
    MemWrite_i = 1'b1; Addr_i = 32'h1064; WriteData_i = 32'hCAFE_F00D; base = stall_cnt;
    serve("t4_fetch", 2, 1'b0, 32'h1060, blk(32'hC0C0_0000), seen);
    check("t4_done_stall", stall_o, 1'b0);
    check("t4_stall_cycles", 32'(stall_cnt - base), 32'd3);
    step();
    MemWrite_i = 1'b0;
    #1 check("t4_load_rdata", ReadData_o, 32'hCAFE_F00D);
    step();

    // 5: conflict on 0x1460 must write back the merged line, then reset mid-fetch
    Addr_i = 32'h1460;
    exp_blk = blk(32'hC0C0_0000);
    exp_blk[63:32] = 32'hCAFE_F00D;
    serve("t5_wb", 4, 1'b1, 32'h1060, '0, seen);
    check("t5_wb_data", seen, exp_blk);
    check("t5_fetch_en", mem_enable_o, 1'b1);
    check("t5_fetch_addr", mem_addr_o, 32'h1460);
    step(); step();
    Reset_n_i = 1'b0;
    #1 check("t5_rst_enable", mem_enable_o, 1'b0);
    check("t5_rst_maddr", mem_addr_o, 32'd0);
    check("t5_rst_idle_stall", stall_o, 1'b1);
    step();
    Reset_n_i = 1'b1;
    serve("t5_refetch", 1, 1'b0, 32'h1460, blk(32'hD0D0_0000), seen);
    check("t5_refetch_rdata", ReadData_o, 32'hD0D0_0000);
    step();

    // 6: stray ack while idle is ignored
    MemRead_i = 1'b0;
    #1 check("t6_idle_rdata", ReadData_o, 32'd0);
    check("t6_idle_stall", stall_o, 1'b0);
    step();
    mem_ack_i = 1'b1; mem_data_i = '1;
    step();
    mem_ack_i = 1'b0;
    check("t6_enable", mem_enable_o, 1'b0);
    MemRead_i = 1'b1; Addr_i = 32'h1460;
    #1 check("t6_rdata", ReadData_o, 32'hD0D0_0000);
    check("t6_stall", stall_o, 1'b0);
    step();
    check("t6_no_req", mem_enable_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
